// File: rtl/lfsr_seq_checker.sv
// ============================================================================
//  Module   : lfsr_seq_checker
//  Brief    : Self-synchronising checker for a 16-bit Fibonacci LFSR word stream.
//             Optional macro LFSR_ERR_CAPTURE_EN adds first-error capture ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_seq_checker #(
  parameter logic [15:0] POLY     = 16'hD008,
  parameter int          LOCK_CNT = 4,
  parameter int          LOSS_CNT = 3,
  parameter int          ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_word,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_o
`ifdef LFSR_ERR_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [15:0]      cap_got,
  output logic [15:0]      cap_exp
`endif
);

  localparam logic [1:0] S_HUNT   = 2'b00;
  localparam logic [1:0] S_VERIFY = 2'b01;
  localparam logic [1:0] S_LOCKED = 2'b10;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  function automatic logic [15:0] f_nxt(input logic [15:0] w);
    return {w[14:0], ^(w & POLY)};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [15:0]      pred_q, pred_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_inc;

  logic             w_match;
  logic [MW-1:0]    w_match_inc;
  logic [LW-1:0]    w_miss_inc;

  assign w_match     = (in_word == pred_q);
  assign w_match_inc = match_q + MW'(1);
  assign w_miss_inc  = miss_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_HUNT: begin
          // The all-zero word is the LFSR lock-up state and cannot seed a prediction.
          if (in_word != 16'h0000) begin
            pred_d  = f_nxt(in_word);
            match_d = '0;
            state_d = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (w_match) begin
            pred_d = f_nxt(in_word);
            if (w_match_inc == MW'(LOCK_CNT)) begin
              state_d = S_LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = w_match_inc;
            end
          end else if (in_word == 16'h0000) begin
            state_d = S_HUNT;
            match_d = '0;
          end else begin
            pred_d  = f_nxt(in_word);
            match_d = '0;
          end
        end
        S_LOCKED: begin
          // Flywheel: once locked, the prediction advances from itself, never from the input.
          pred_d = f_nxt(pred_q);
          if (w_match) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (w_miss_inc == LW'(LOSS_CNT)) begin
              state_d = S_HUNT;
              miss_d  = '0;
            end else begin
              miss_d = w_miss_inc;
            end
          end
        end
        default: begin
          state_d = S_HUNT;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == S_LOCKED);

    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HUNT;
      pred_q      <= 16'h0000;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign state_o   = state_q;

`ifdef LFSR_ERR_CAPTURE_EN
  logic        cap_valid_q, cap_valid_d;
  logic [15:0] cap_got_q, cap_got_d;
  logic [15:0] cap_exp_q, cap_exp_d;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_got_d   = cap_got_q;
    cap_exp_d   = cap_exp_q;
    if (clr_cnt) begin
      cap_valid_d = 1'b0;
      cap_got_d   = 16'h0000;
      cap_exp_d   = 16'h0000;
    end else if (err_inc && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_got_d   = in_word;
      cap_exp_d   = pred_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_got_q   <= 16'h0000;
      cap_exp_q   <= 16'h0000;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_got_q   <= cap_got_d;
      cap_exp_q   <= cap_exp_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_got   = cap_got_q;
  assign cap_exp   = cap_exp_q;
`else
  // Capture disabled: no extra ports or state.
`endif

endmodule

`default_nettype wire
